// File: rtl/piso_serializer_if.sv
// Handshake bundle for piso_serializer: parallel word in, serial bit stream out.
// slave is the serializer's view; master is the view of whatever drives it.
interface piso_serializer_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_data;
    logic         s_last;
    logic         frame_done;
    logic         busy;
    logic [1:0]   state_dbg;

    // Both sides use plain valid/ready: a transfer happens on a rising clk edge
    // where valid && ready; a source holds its payload stable until that edge.
    modport slave (
        input  in_valid, in_data, s_ready,
        output in_ready, s_valid, s_data, s_last, frame_done, busy, state_dbg
    );

    modport master (
        output in_valid, in_data, s_ready,
        input  in_ready, s_valid, s_data, s_last, frame_done, busy, state_dbg
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: N-bit words in, MSB-first bit stream out.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t        state, state_d;
    logic [N-1:0]  shreg, shreg_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          done_q, done_d;
    logic          in_ready_c, s_valid_c, s_data_c, s_last_c;
`ifdef PISO_PARITY_EN
    logic          par, par_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            shreg  <= shreg_d;
            cnt    <= cnt_d;
            done_q <= done_d;
`ifdef PISO_PARITY_EN
            par    <= par_d;
`endif
        end
    end

    // Outputs depend on state only; in_valid and s_ready steer next-state alone.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        cnt_d      = cnt;
        done_d     = 1'b0;
        in_ready_c = 1'b0;
        s_valid_c  = 1'b0;
        s_data_c   = 1'b0;
        s_last_c   = 1'b0;
`ifdef PISO_PARITY_EN
        par_d      = par;
`endif
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    shreg_d = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^bus.in_data;
`endif
                end
            end
            SHIFT: begin
                s_valid_c = 1'b1;
                s_data_c  = shreg[N-1];
`ifndef PISO_PARITY_EN
                s_last_c  = (cnt == CNT_LAST);
`endif
                if (bus.s_ready) begin
                    shreg_d = {shreg[N-2:0], 1'b0};
                    if (cnt == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                s_valid_c = 1'b1;
                s_data_c  = par;
                s_last_c  = 1'b1;
                if (bus.s_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // in_ready is gated by reset so no word is taken while rst_n is low.
    assign bus.in_ready   = in_ready_c & rst_n;
    assign bus.s_valid    = s_valid_c;
    assign bus.s_data     = s_data_c;
    assign bus.s_last     = s_last_c;
    assign bus.frame_done = done_q;
    assign bus.busy       = (state != IDLE);
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_piso_serializer.sv
// Randomised and directed bench for piso_serializer with a bit-level scoreboard.
// Build with or without PISO_PARITY_EN; the reference model follows the same macro.
module tb_piso_serializer;
    localparam int N = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    piso_serializer_if #(.N(N)) bus ();
    piso_serializer #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bits_acc = 0;
    int stall_at = -1;
    int stall_left = 0;
    int sink_mode = 0;
    int last_acc_edge = 0;
    int last_done_edge = 0;
    logic [1:0] exp_q[$];  // {data, last}
    bit done_due = 1'b0;
    bit after_rst = 1'b0;
    bit hold_valid = 1'b0;
    logic hold_data = 1'b0;
    logic hold_last = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic even_parity(input logic [N-1:0] w);
        int ones = 0;
        for (int i = 0; i < N; i++) if (w[i]) ones++;
        return (ones % 2) == 1;
    endfunction

    // Reference model: a frame is the word's bits MSB-first, plus parity if enabled.
    task automatic push_frame(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
            exp_q.push_back({w[i], 1'b0});
`else
            exp_q.push_back({w[i], i == 0});
`endif
        end
`ifdef PISO_PARITY_EN
        exp_q.push_back({even_parity(w), 1'b1});
`endif
    endtask

    // Monitor: samples at negedge, where inputs and outputs are both stable.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst_n) begin
            chk1("in_ready_in_reset", bus.in_ready, 1'b0);
            exp_q.delete();
            done_due   = 1'b0;
            hold_valid = 1'b0;
            after_rst  = 1'b1;
            bits_acc   = 0;
        end else begin
            if (after_rst) begin
                chk1("rst_s_valid", bus.s_valid, 1'b0);
                chk1("rst_s_data", bus.s_data, 1'b0);
                chk1("rst_s_last", bus.s_last, 1'b0);
                chk1("rst_busy", bus.busy, 1'b0);
                chk1("rst_in_ready", bus.in_ready, 1'b1);
                after_rst = 1'b0;
            end
            chk1("frame_done", bus.frame_done, done_due);
            if (done_due) begin
                chk1("idle_gap_s_valid", bus.s_valid, 1'b0);
                chk1("in_ready_at_done", bus.in_ready, 1'b1);
            end
            done_due = 1'b0;
            chk1("busy_vs_s_valid", bus.busy, bus.s_valid);
            if (bus.s_valid) chk1("in_ready_during_frame", bus.in_ready, 1'b0);
            if (hold_valid) begin
                chk1("stall_s_valid", bus.s_valid, 1'b1);
                chk1("stall_s_data", bus.s_data, hold_data);
                chk1("stall_s_last", bus.s_last, hold_last);
            end
            if (bus.s_valid && bus.s_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got bit %0b with nothing expected (cycle %0d)",
                             bus.s_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk1("s_data", bus.s_data, e[1]);
                    chk1("s_last", bus.s_last, e[0]);
                    bits_acc++;
                    if (e[0]) begin
                        done_due       = 1'b1;
                        last_done_edge = cyc + 1;
                        bits_acc       = 0;
                    end
                end
            end
            hold_valid = bus.s_valid && !bus.s_ready;
            hold_data  = bus.s_data;
            hold_last  = bus.s_last;
        end
    end

    // Sink: drives s_ready just after each rising edge.
    initial begin
        bus.s_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && bits_acc == stall_at) begin
                bus.s_ready = 1'b0;
                stall_left--;
            end else if (sink_mode == 1) begin
                bus.s_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.s_ready = 1'b1;
            end
        end
    end

    // Offers a word until accepted; returns just after the accepting edge.
    task automatic send_word(input logic [N-1:0] w, input bit keep);
        int n = 0;
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!got) begin
            @(negedge clk);
            if (bus.in_ready && rst_n) begin
                got = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", n);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        push_frame(w);
        last_acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || bus.s_valid) && n < 500);
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d bits still expected, s_valid=%0b", exp_q.size(), bus.s_valid);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [N-1:0] w;
        bit keep;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single words with s_ready held high.
        send_word(8'hA5, 1'b0);
        wait_idle();
        chk_int("a5_frame_len", last_done_edge - last_acc_edge, FRAME);
        send_word(8'h07, 1'b0);
        wait_idle();
        chk_int("07_frame_len", last_done_edge - last_acc_edge, FRAME);

        // Three stall cycles after the second bit.
        stall_at   = 2;
        stall_left = 3;
        send_word(8'hC3, 1'b0);
        wait_idle();
        chk_int("c3_frame_len", last_done_edge - last_acc_edge, FRAME + 3);
        chk_int("c3_stalls_used", stall_left, 0);
        stall_at = -1;

        // Back-to-back with in_valid held high.
        send_word(8'hFF, 1'b1);
        n = last_acc_edge;
        send_word(8'h00, 1'b0);
        chk_int("b2b_accept_spacing", last_acc_edge - n, FRAME + 1);
        wait_idle();

        // Reset after the fourth bit, then a fresh frame.
        send_word(8'h5A, 1'b0);
        n = 0;
        while (bits_acc < 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(8'h81, 1'b0);
        wait_idle();

        // A stray in_valid pulse during SHIFT must be ignored.
        send_word(8'h3C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hE7;
        @(negedge clk);
        chk1("pulse_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;

        // Random words, gaps and backpressure.
        sink_mode = 1;
        for (int k = 0; k < 150; k++) begin
            w    = N'($urandom);
            keep = ($urandom_range(0, 3) == 0);
            send_word(w, keep);
            if (!keep) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        wait_idle();
        sink_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_int("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out front end for the parallel-load shift register stage. It accepts N-bit words on a valid/ready handshake and emits them MSB-first as a bit stream with its own valid/ready handshake. The stream drives the downstream register's serial input and shift enable. Frame boundaries are marked with a last-bit flag and a completion pulse.

## Interface
- N, default 8, data word width in bits; legal range N >= 2

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word this cycle
- in_data  input  N  parallel word, sampled when in_valid && in_ready
- s_valid  output  1  s_data holds a valid bit
- s_ready  input  1  downstream accepts the bit (downstream shift enable)
- s_data  output  1  current serial bit
- s_last  output  1  current bit is the final bit of the frame
- frame_done  output  1  one-cycle pulse after the final bit handshake
- busy  output  1  frame in progress (state != IDLE)

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro defined).
- IDLE
  - in_ready = 1; s_valid = 0.
  - On in_valid && in_ready: load in_data into the shift register, clear the bit counter, go to SHIFT.
- SHIFT
  - in_ready = 0; s_valid = 1; s_data = shreg[N-1].
  - On s_valid && s_ready: shift left by one with 0 fill, counter += 1.
  - On acceptance of bit N-1 (counter == N-1): go to PARITY if enabled, else go to IDLE.
- PARITY
  - s_valid = 1; s_data = even parity (XOR of all N bits of the captured word).
  - On s_ready: go to IDLE.
- Bit counter width is $clog2(N). The counter never exceeds N-1.
- s_last = 1 on the final bit: bit N-1 without parity, or the parity bit with parity.
- frame_done is registered. It is high for exactly one cycle: the cycle after the final bit handshake, which is also the first cycle back in IDLE.
- Backpressure: while s_valid && !s_ready, s_data, s_last, the state and the counter all hold.
- in_data is ignored outside IDLE. in_valid held high during a frame has no effect until IDLE.
- Reset, including mid-frame: on a clk edge with rst_n = 0, the next state is IDLE with the shift register, counter and parity cleared and frame_done = 0.
  - While rst_n = 0, in_ready is forced to 0.
  - The partial frame is discarded and never resumed.
- Reset values: in_ready 0 (while rst_n low), s_valid 0, s_data 0, s_last 0, frame_done 0, busy 0.

## Timing
- Handshake at edge t in IDLE → s_valid = 1 in cycle t+1 with the MSB on s_data.
- With s_ready held at 1: N bits in N consecutive cycles (N+1 with parity), then one IDLE cycle.
- Sustained throughput is one word per N+1 cycles (N+2 with parity). in_ready is low from the load edge until return to IDLE.
- Each s_ready low cycle adds exactly one cycle of latency. No bit is dropped or duplicated.
- No combinational path from in_valid/in_data to any output. s_ready affects only next-state logic.

## Configuration
- PISO_PARITY_EN
  - Defined: the PARITY state is compiled in, each frame is N+1 bits, and s_last marks the parity bit.
  - Undefined: the PARITY state and parity logic are absent, frames are N bits, and s_last marks data bit N-1.

## Test plan
- N=8, no macro, s_ready = 1, in_data = 8'hA5 → s_data sequence 1,0,1,0,0,1,0,1 over 8 cycles, s_last on the 8th bit, frame_done one cycle later, in_ready back to 1 in that same cycle.
- Macro defined, in_data = 8'hA5 then 8'h07 → A5 bits followed by parity 0; 07 bits followed by parity 1; 9 bits per frame, s_last on the parity bit.
- Backpressure: word 8'hC3, s_ready low for 3 cycles after bit 2 → s_data holds 0 during the stall, the full sequence 1,1,0,0,0,0,1,1 is intact, and the frame takes 8+3 cycles.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 → in_ready low throughout frame 1; second word captured in the frame_done cycle; exactly one s_valid = 0 cycle between frames.
- Reset mid-frame: rst_n low for 1 cycle after bit 4 of 8'h5A → next cycle all outputs at reset values, no frame_done. A new word 8'h81 afterwards serializes correctly as 1,0,0,0,0,0,0,1.
- in_valid pulsed during SHIFT with a different word → ignored; current frame unaffected; no extra frame emitted.
